spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on i_spi_sclk/i_spi_cs/i_spi_mosi.
REQ-002 SHALL have parameter FILL_BYTE, default 8'hFF, byte shifted out when no TX data is held.
REQ-003 SHALL have port i_clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_config_valid input 1 and i_config_data input 4: config write strobe and data; bit3 CPOL, bit2 CPHA, bit1 LSB-first, bit0 CS active-high.
REQ-006 SHALL have ports i_tx_data_valid input 1, i_tx_data_byte input 8, o_tx_ready output 1: valid/ready TX byte handshake.
REQ-007 SHALL have ports o_rx_data_valid output 1 and o_rx_data_byte output 8: one-cycle received-byte strobe and data.
REQ-008 SHALL have ports i_spi_sclk, i_spi_cs, i_spi_mosi input 1 each (asynchronous), o_spi_miso output 1, o_spi_miso_oe output 1.

Function
REQ-009 SHALL pass SCLK/CS/MOSI through SYNC_STAGES flops and detect SCLK edges/CS assertion in i_clk domain; each SCLK phase SHALL be >= SYNC_STAGES+2 i_clk cycles (supported-use limit).
REQ-010 SHALL implement states IDLE (CS inactive), LOAD (one cycle: load shift register), SHIFT (bit counter 0..7).
REQ-011 IDLE->LOAD on synchronized CS assertion; LOAD->SHIFT unconditionally; SHIFT->LOAD after 8th sample edge while CS still asserted; any state->IDLE on CS deassertion.
REQ-012 Leading edge = rising when CPOL=0, falling when CPOL=1.
REQ-013 CPHA=0: first TX bit on MISO from LOAD; sample MOSI on leading edge, drive next bit on trailing edge.
REQ-014 CPHA=1: drive bit on leading edge, sample MOSI on trailing edge.
REQ-015 Bit order: MSB first when LSB-first=0, else LSB first, for both TX and RX.
REQ-016 o_rx_data_valid SHALL pulse exactly one i_clk cycle, 1 cycle after the 8th sample edge, with o_rx_data_byte holding until the next pulse.
REQ-017 One-byte TX holding register; o_tx_ready=1 when empty; capture on i_tx_data_valid && o_tx_ready; i_tx_data_valid while not ready SHALL be ignored.
REQ-018 LOAD SHALL consume the holding register (o_tx_ready rises next cycle), or load FILL_BYTE if empty.
REQ-019 Capture on the same cycle as LOAD consumption of an empty register SHALL be deferred to the next byte.
REQ-020 CS deasserted mid-byte: partial RX discarded, no o_rx_data_valid, holding register untouched.
REQ-021 o_spi_miso_oe=1 only outside IDLE; o_spi_miso=0 in IDLE.
REQ-022 i_config_valid SHALL update config only in IDLE; ignored otherwise.

Reset
REQ-023 On i_rst: state IDLE, config 4'b0000, holding empty, o_tx_ready=1, o_rx_data_valid=0, o_rx_data_byte=8'h00, o_spi_miso=0, o_spi_miso_oe=0, synchronizers cleared to CS-inactive for config bit0=0.
REQ-024 Reset mid-transfer SHALL abandon the byte; a transfer starts only after a fresh CS assertion.

Configuration
REQ-025 Macro SPI_SLAVE_ERR_EN defined: adds outputs o_rx_overrun (1-cycle pulse when a byte completes before... prior byte's strobe cycle overlaps; i.e. back-to-back pulse within 1 cycle) and o_tx_underrun (1-cycle pulse when FILL_BYTE is loaded); both reset 0.
REQ-026 Macro undefined: these ports and their logic SHALL not exist; behaviour otherwise identical.

Structure
REQ-027 Package spi_pkg SHALL hold spi_cfg_t (cpol, cpha, lsb_first, cs_active_high), the state enum, and bit-count width constant.
REQ-028 Sub-module spi_sync SHALL implement SYNC_STAGES-deep synchronizer with rise/fall outputs, instantiated per SPI input.

Verification
REQ-029 Mode 0, MSB-first, TX 8'hA5 preloaded, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; o_rx_data_byte=8'h3C with one valid pulse.
REQ-030 Modes 1, 2, 3 each: TX 8'h25, master sends 8'h8E -> master reads 8'h25, slave reads 8'h8E.
REQ-031 LSB-first, CS active-high, TX 8'h14 -> MISO order 0,0,1,0,1,0,0,0; RX 8'h14 in loopback.
REQ-032 CS held for two bytes, only 8'h11 loaded -> second byte transmits 8'hFF; o_tx_underrun pulses once if SPI_SLAVE_ERR_EN.
REQ-033 CS deasserted after 5 bits -> no o_rx_data_valid; next full transfer of 8'h5A received correctly.
REQ-034 i_rst asserted mid-byte -> all outputs at REQ-023 values same cycle; i_config_valid during SHIFT -> config unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: config payload, FSM states, bit-order helpers.
package spi_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned CFG_W     = 4;

    // Field order matches the config write word: bit3 cpol .. bit0 cs_active_high.
    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
        logic cs_active_high;
    } spi_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    function automatic logic first_bit(input logic [BYTE_W-1:0] b, input logic lsb_first);
        return lsb_first ? b[0] : b[BYTE_W-1];
    endfunction

    function automatic logic [BYTE_W-1:0] shift_out(input logic [BYTE_W-1:0] b, input logic lsb_first);
        return lsb_first ? (b >> 1) : (b << 1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with edge strobes in the i_clk domain.
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   q_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= {SYNC_STAGES{RST_VAL}};
            q_prev <= RST_VAL;
        end else begin
            stages <= (stages << 1) | SYNC_STAGES'(d);
            q_prev <= stages[SYNC_STAGES-1];
        end
    end

    assign q      = stages[SYNC_STAGES-1];
    assign rise_c = q & ~q_prev;
    assign fall_c = ~q & q_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, selectable bit order and CS polarity, one-byte TX holding register.
// Optional error strobes (o_rx_overrun, o_tx_underrun) when SPI_SLAVE_ERR_EN is defined.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0]  FILL_BYTE   = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_config_valid,
    input  logic [CFG_W-1:0]  i_config_data,
    input  logic              i_tx_data_valid,
    input  logic [BYTE_W-1:0] i_tx_data_byte,
    output logic              o_tx_ready,
    output logic              o_rx_data_valid,
    output logic [BYTE_W-1:0] o_rx_data_byte,
    input  logic              i_spi_sclk,
    input  logic              i_spi_cs,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic              o_rx_overrun,
    output logic              o_tx_underrun
`endif
);

    spi_cfg_t              cfg;
    spi_state_e            state, state_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0]     tx_shift, rx_shift, hold_byte;
    logic                  hold_valid;

    logic sclk_q_unused, sclk_rise_c, sclk_fall_c;
    logic cs_q, cs_rise_unused, cs_fall_unused;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(i_clk), .rst(i_rst), .d(i_spi_sclk),
        .q(sclk_q_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );
    // CS resets to the inactive level of the default active-low polarity.
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(i_clk), .rst(i_rst), .d(i_spi_cs),
        .q(cs_q), .rise_c(cs_rise_unused), .fall_c(cs_fall_unused)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(i_clk), .rst(i_rst), .d(i_spi_mosi),
        .q(mosi_q), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
    );

    logic              cs_active_c, lead_c, trail_c, sample_c, drive_c, byte_done_c;
    logic [BYTE_W-1:0] load_byte_c, rx_next_c;

    // The CPHA=0 trailing edge that closes a byte must not shift the freshly loaded byte.
    assign cs_active_c = cfg.cs_active_high ? cs_q : ~cs_q;
    assign lead_c      = cfg.cpol ? sclk_fall_c : sclk_rise_c;
    assign trail_c     = cfg.cpol ? sclk_rise_c : sclk_fall_c;
    assign sample_c    = cfg.cpha ? trail_c : lead_c;
    assign drive_c     = (cfg.cpha ? lead_c : trail_c) && (cfg.cpha || (bit_cnt != '0));
    assign byte_done_c = (state == ST_SHIFT) && sample_c && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
    assign load_byte_c = hold_valid ? hold_byte : FILL_BYTE;
    assign rx_next_c   = cfg.lsb_first ? {mosi_q, rx_shift[BYTE_W-1:1]}
                                       : {rx_shift[BYTE_W-2:0], mosi_q};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cs_active_c) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (byte_done_c) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!cs_active_c) state_nxt = ST_IDLE;
    end

    // Datapath: config, holding register, shifters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cfg             <= '0;
            bit_cnt         <= '0;
            tx_shift        <= '0;
            rx_shift        <= '0;
            hold_byte       <= '0;
            hold_valid      <= 1'b0;
            o_tx_ready      <= 1'b1;
            o_rx_data_valid <= 1'b0;
            o_rx_data_byte  <= '0;
            o_spi_miso      <= 1'b0;
            o_spi_miso_oe   <= 1'b0;
        end else begin
            o_rx_data_valid <= 1'b0;
            if (state == ST_IDLE && i_config_valid) cfg <= spi_cfg_t'(i_config_data);

            if (state == ST_LOAD && hold_valid) begin
                hold_valid <= 1'b0;
                o_tx_ready <= 1'b1;
            end else if (i_tx_data_valid && o_tx_ready) begin
                hold_byte  <= i_tx_data_byte;
                hold_valid <= 1'b1;
                o_tx_ready <= 1'b0;
            end

            case (state)
                ST_LOAD: begin
                    bit_cnt <= '0;
                    if (cfg.cpha) begin
                        tx_shift <= load_byte_c;
                    end else begin
                        o_spi_miso <= first_bit(load_byte_c, cfg.lsb_first);
                        tx_shift   <= shift_out(load_byte_c, cfg.lsb_first);
                    end
                end
                ST_SHIFT: begin
                    if (sample_c) begin
                        rx_shift <= rx_next_c;
                        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                    end
                    if (drive_c) begin
                        o_spi_miso <= first_bit(tx_shift, cfg.lsb_first);
                        tx_shift   <= shift_out(tx_shift, cfg.lsb_first);
                    end
                    if (byte_done_c && cs_active_c) begin
                        o_rx_data_valid <= 1'b1;
                        o_rx_data_byte  <= rx_next_c;
                    end
                end
                default: ;
            endcase

            if (state_nxt == ST_IDLE) o_spi_miso <= 1'b0;
            o_spi_miso_oe <= (state_nxt != ST_IDLE);
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    // Overrun: a new byte completes while the previous strobe is still being presented.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_overrun  <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            o_rx_overrun  <= byte_done_c && cs_active_c && o_rx_data_valid;
            o_tx_underrun <= (state == ST_LOAD) && !hold_valid;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master, hand-computed expected bytes.
module tb_spi_slave;

    localparam int unsigned H = 8;

    logic       tb_clk = 1'b0;
    logic       i_rst, i_config_valid, i_tx_data_valid;
    logic [3:0] i_config_data;
    logic [7:0] i_tx_data_byte, o_rx_data_byte;
    logic       o_tx_ready, o_rx_data_valid;
    logic       i_spi_sclk, i_spi_cs, i_spi_mosi, o_spi_miso, o_spi_miso_oe;

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_last = 8'h00;
    logic [3:0] cur_cfg = 4'h0;

`ifdef SPI_SLAVE_ERR_EN
    logic o_rx_overrun, o_tx_underrun;
    int   under_cnt = 0;
    int   over_cnt  = 0;
    always @(negedge tb_clk) begin
        if (o_tx_underrun) under_cnt++;
        if (o_rx_overrun)  over_cnt++;
    end
`endif

    always #5 tb_clk = ~tb_clk;

    always @(negedge tb_clk) if (o_rx_data_valid) begin
        rx_cnt++;
        rx_last = o_rx_data_byte;
    end

    spi_slave dut (
        .i_clk(tb_clk), .i_rst(i_rst),
        .i_config_valid(i_config_valid), .i_config_data(i_config_data),
        .i_tx_data_valid(i_tx_data_valid), .i_tx_data_byte(i_tx_data_byte), .o_tx_ready(o_tx_ready),
        .o_rx_data_valid(o_rx_data_valid), .o_rx_data_byte(o_rx_data_byte),
        .i_spi_sclk(i_spi_sclk), .i_spi_cs(i_spi_cs), .i_spi_mosi(i_spi_mosi),
        .o_spi_miso(o_spi_miso), .o_spi_miso_oe(o_spi_miso_oe)
`ifdef SPI_SLAVE_ERR_EN
        , .o_rx_overrun(o_rx_overrun), .o_tx_underrun(o_tx_underrun)
`endif
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic set_config(input logic [3:0] c);
        @(negedge tb_clk);
        i_config_valid = 1'b1;
        i_config_data  = c;
        @(negedge tb_clk);
        i_config_valid = 1'b0;
    endtask

    task automatic load_tx(input logic [7:0] b);
        i_tx_data_valid = 1'b1;
        i_tx_data_byte  = b;
        @(negedge tb_clk);
        i_tx_data_valid = 1'b0;
    endtask

    task automatic cs_set(input logic active);
        i_spi_cs = cur_cfg[0] ? active : ~active;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_spi_cs = 1'b1;
        i_spi_sclk = 1'b0;
        cur_cfg = 4'h0;
        wait_clk(3);
        i_rst = 1'b0;
        wait_clk(4);
    endtask

    // Master side: mi is the byte read from MISO, seq the MISO bits in time order (first in [7]).
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi, output logic [7:0] seq);
        logic cpol, cpha, lsb;
        int   idx;
        cpol = cur_cfg[3];
        cpha = cur_cfg[2];
        lsb  = cur_cfg[1];
        mi   = 8'h00;
        seq  = 8'h00;
        if (!cpha) begin
            i_spi_mosi = mo[lsb ? 0 : 7];
            wait_clk(H);
            for (int i = 0; i < nbits; i++) begin
                idx = lsb ? i : 7 - i;
                mi[idx] = o_spi_miso;
                seq = {seq[6:0], o_spi_miso};
                i_spi_sclk = ~cpol;
                wait_clk(H);
                i_spi_sclk = cpol;
                if (i < 7) i_spi_mosi = mo[lsb ? i + 1 : 6 - i];
                wait_clk(H);
            end
        end else begin
            wait_clk(H);
            for (int i = 0; i < nbits; i++) begin
                idx = lsb ? i : 7 - i;
                i_spi_sclk = ~cpol;
                i_spi_mosi = mo[idx];
                wait_clk(H);
                mi[idx] = o_spi_miso;
                seq = {seq[6:0], o_spi_miso};
                i_spi_sclk = cpol;
                wait_clk(H);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_config_valid = 1'b0; i_config_data = 4'h0;
        i_tx_data_valid = 1'b0; i_tx_data_byte = 8'h00;
        i_spi_sclk = 1'b0; i_spi_cs = 1'b1; i_spi_mosi = 1'b0;
        wait_clk(3);
        i_rst = 1'b0;
        wait_clk(5);
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", o_tx_ready); end
        checks++; if (o_rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", o_rx_data_valid); end
        checks++; if (o_rx_data_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h exp 00", o_rx_data_byte); end
        checks++; if (o_spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", o_spi_miso); end
        checks++; if (o_spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe got %b exp 0", o_spi_miso_oe); end
    endtask

    task automatic test_mode0();
        logic [7:0] mi, seq;
        int n0;
        load_tx(8'hA5);
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL m0_ready_full got %b exp 0", o_tx_ready); end
        n0 = rx_cnt;
        cs_set(1'b1);
        wait_clk(6);
        checks++; if (o_spi_miso_oe !== 1'b1) begin errors++; $display("FAIL m0_oe_active got %b exp 1", o_spi_miso_oe); end
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL m0_ready_consumed got %b exp 1", o_tx_ready); end
        xfer(8'h3C, 8, mi, seq);
        cs_set(1'b0);
        wait_clk(H);
        checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL m0_miso_byte got %h exp a5", mi); end
        checks++; if (seq !== 8'b1010_0101) begin errors++; $display("FAIL m0_miso_order got %b exp 10100101", seq); end
        checks++; if (rx_cnt - n0 !== 1) begin errors++; $display("FAIL m0_rx_pulses got %0d exp 1", rx_cnt - n0); end
        checks++; if (rx_last !== 8'h3C) begin errors++; $display("FAIL m0_rx_byte got %h exp 3c", rx_last); end
        checks++; if (o_spi_miso_oe !== 1'b0) begin errors++; $display("FAIL m0_oe_idle got %b exp 0", o_spi_miso_oe); end
        checks++; if (o_spi_miso !== 1'b0) begin errors++; $display("FAIL m0_miso_idle got %b exp 0", o_spi_miso); end
    endtask

    task automatic test_modes();
        logic [7:0] mi, seq;
        logic [1:0] m;
        int n0;
        for (int k = 1; k <= 3; k++) begin
            m = 2'(k);
            i_spi_sclk = m[1];
            wait_clk(4);
            cur_cfg = {m[1], m[0], 2'b00};
            set_config(cur_cfg);
            load_tx(8'h25);
            n0 = rx_cnt;
            cs_set(1'b1);
            wait_clk(6);
            xfer(8'h8E, 8, mi, seq);
            cs_set(1'b0);
            wait_clk(H);
            checks++; if (mi !== 8'h25) begin errors++; $display("FAIL mode%0d_miso got %h exp 25", k, mi); end
            checks++; if (rx_last !== 8'h8E) begin errors++; $display("FAIL mode%0d_rx got %h exp 8e", k, rx_last); end
            checks++; if (rx_cnt - n0 !== 1) begin errors++; $display("FAIL mode%0d_pulses got %0d exp 1", k, rx_cnt - n0); end
        end
        i_spi_sclk = 1'b0;
        wait_clk(4);
        cur_cfg = 4'h0;
        set_config(cur_cfg);
    endtask

    task automatic test_lsb_cs_high();
        logic [7:0] mi, seq;
        i_spi_cs = 1'b0;
        cur_cfg = 4'b0011;
        set_config(cur_cfg);
        wait_clk(4);
        load_tx(8'h14);
        cs_set(1'b1);
        wait_clk(6);
        checks++; if (o_spi_miso_oe !== 1'b1) begin errors++; $display("FAIL lsb_oe got %b exp 1", o_spi_miso_oe); end
        xfer(8'h14, 8, mi, seq);
        cs_set(1'b0);
        wait_clk(H);
        checks++; if (seq !== 8'b0010_1000) begin errors++; $display("FAIL lsb_miso_order got %b exp 00101000", seq); end
        checks++; if (mi !== 8'h14) begin errors++; $display("FAIL lsb_miso_byte got %h exp 14", mi); end
        checks++; if (rx_last !== 8'h14) begin errors++; $display("FAIL lsb_rx got %h exp 14", rx_last); end
        do_reset();
    endtask

    task automatic test_two_bytes();
        logic [7:0] mi1, mi2, seq;
        int n0;
`ifdef SPI_SLAVE_ERR_EN
        int u0;
        u0 = under_cnt;
`endif
        load_tx(8'h11);
        n0 = rx_cnt;
        cs_set(1'b1);
        wait_clk(6);
        xfer(8'hC3, 8, mi1, seq);
`ifdef SPI_SLAVE_ERR_EN
        checks++; if (under_cnt - u0 !== 1) begin errors++; $display("FAIL two_underrun got %0d exp 1", under_cnt - u0); end
`endif
        xfer(8'h3C, 8, mi2, seq);
        cs_set(1'b0);
        wait_clk(H);
        checks++; if (mi1 !== 8'h11) begin errors++; $display("FAIL two_byte1 got %h exp 11", mi1); end
        checks++; if (mi2 !== 8'hFF) begin errors++; $display("FAIL two_byte2_fill got %h exp ff", mi2); end
        checks++; if (rx_cnt - n0 !== 2) begin errors++; $display("FAIL two_pulses got %0d exp 2", rx_cnt - n0); end
        checks++; if (rx_last !== 8'h3C) begin errors++; $display("FAIL two_rx got %h exp 3c", rx_last); end
    endtask

    task automatic test_abort();
        logic [7:0] mi, seq;
        int n0;
        n0 = rx_cnt;
        cs_set(1'b1);
        wait_clk(6);
        load_tx(8'h66);
        xfer(8'hF0, 5, mi, seq);
        cs_set(1'b0);
        wait_clk(2 * H);
        checks++; if (rx_cnt !== n0) begin errors++; $display("FAIL abort_no_pulse got %0d exp %0d", rx_cnt, n0); end
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL abort_hold_kept got %b exp 0", o_tx_ready); end
        cs_set(1'b1);
        wait_clk(6);
        xfer(8'h5A, 8, mi, seq);
        cs_set(1'b0);
        wait_clk(H);
        checks++; if (rx_last !== 8'h5A) begin errors++; $display("FAIL abort_next_rx got %h exp 5a", rx_last); end
        checks++; if (rx_cnt - n0 !== 1) begin errors++; $display("FAIL abort_next_pulses got %0d exp 1", rx_cnt - n0); end
        checks++; if (mi !== 8'h66) begin errors++; $display("FAIL abort_next_miso got %h exp 66", mi); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi, seq;
        cs_set(1'b1);
        wait_clk(6);
        load_tx(8'h77);
        xfer(8'hAA, 3, mi, seq);
        i_rst = 1'b1;
        #1;
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready got %b exp 1", o_tx_ready); end
        checks++; if (o_rx_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid got %b exp 0", o_rx_data_valid); end
        checks++; if (o_rx_data_byte !== 8'h00) begin errors++; $display("FAIL rstmid_rx_byte got %h exp 00", o_rx_data_byte); end
        checks++; if (o_spi_miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b exp 0", o_spi_miso); end
        checks++; if (o_spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b exp 0", o_spi_miso_oe); end
        do_reset();
        load_tx(8'hC4);
        cs_set(1'b1);
        wait_clk(6);
        xfer(8'h96, 8, mi, seq);
        cs_set(1'b0);
        wait_clk(H);
        checks++; if (mi !== 8'hC4) begin errors++; $display("FAIL rstmid_fresh_miso got %h exp c4", mi); end
        checks++; if (rx_last !== 8'h96) begin errors++; $display("FAIL rstmid_fresh_rx got %h exp 96", rx_last); end
    endtask

    task automatic test_config_lock();
        logic [7:0] mi, seq;
        cs_set(1'b1);
        wait_clk(6);
        set_config(4'b1100);
        xfer(8'hB7, 8, mi, seq);
        cs_set(1'b0);
        wait_clk(H);
        checks++; if (rx_last !== 8'hB7) begin errors++; $display("FAIL cfglock_rx1 got %h exp b7", rx_last); end
        cs_set(1'b1);
        wait_clk(6);
        xfer(8'h3A, 8, mi, seq);
        cs_set(1'b0);
        wait_clk(H);
        checks++; if (rx_last !== 8'h3A) begin errors++; $display("FAIL cfglock_rx2 got %h exp 3a", rx_last); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_lsb_cs_high();
        test_two_bytes();
        test_abort();
        test_reset_mid();
        test_config_lock();
`ifdef SPI_SLAVE_ERR_EN
        checks++; if (over_cnt !== 0) begin errors++; $display("FAIL overrun_count got %0d exp 0", over_cnt); end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
